// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/lock inputs and grant/owner outputs of the round-robin bus arbiter
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W = 2
);
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] lock;
  logic [NUM_MASTERS-1:0] grnt;
  logic [OWNER_W-1:0] owner;
  logic owner_valid;
  logic timeout;
  modport master (output req, lock, input grnt, owner, owner_valid, timeout);
  modport slave (input req, lock, output grnt, owner, owner_valid, timeout);
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin arbiter with registered one-hot grant and max-hold rotation
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W = 2,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W = 5
) (
  input logic clk,
  input logic reset,
  bus_arbiter_rr_if.slave bus
);
  typedef enum logic {IDLE, GRANTED} state_t;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);
  state_t state;
  logic [HOLD_W-1:0] hold;
  logic [NUM_MASTERS-1:0] others, cand;
  logic [OWNER_W-1:0] win;
  logic found, force_rot;
  int idx;
  always_comb begin
    others = bus.req;
    others[bus.owner] = 1'b0;
  end
  // In IDLE the owner itself may win last; when granted it is always excluded
  assign cand = (state == IDLE) ? bus.req : others;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(bus.owner) + i) % NUM_MASTERS;
      if (!found && cand[idx]) begin
        win = OWNER_W'(idx);
        found = 1'b1;
      end
    end
  end
  assign force_rot = (MAX_HOLD != 0) && (hold == HOLD_MAX) && !bus.lock[bus.owner] && (|others);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bus.grnt <= '0;
      bus.owner <= OWNER_W'(NUM_MASTERS - 1);
      bus.owner_valid <= 1'b0;
      bus.timeout <= 1'b0;
      hold <= '0;
    end else begin
      bus.timeout <= 1'b0;
      if (state == IDLE) begin
        if (|bus.req) begin
          state <= GRANTED;
          bus.grnt <= ONE << win;
          bus.owner <= win;
          bus.owner_valid <= 1'b1;
          hold <= '0;
        end
      end else if (!bus.req[bus.owner]) begin
        hold <= '0;
        if (|others) begin
          bus.grnt <= ONE << win;
          bus.owner <= win;
        end else begin
          state <= IDLE;
          bus.grnt <= '0;
          bus.owner_valid <= 1'b0;
        end
      end else if (force_rot) begin
        bus.grnt <= ONE << win;
        bus.owner <= win;
        bus.timeout <= 1'b1;
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
      end
    end
  end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-master bus arbiter with registered one-hot grants.
- Round-robin fairness, with no bubble cycle on handover.
- Optional maximum-hold timeout forces rotation; a per-master lock exempts a master from the timeout.
- Sits between the bus masters (CPU, DMA and similar) and the shared bus multiplexer; the owner index drives the address/data mux select.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- OWNER_W, 2, width of the owner index; must be ≥ ceil(log2(NUM_MASTERS)).
- MAX_HOLD, 16, max consecutive granted cycles while another master waits; 0 disables the timeout.
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- req, input, NUM_MASTERS: per-master bus request, active-high, level-held while the master wants the bus.
- lock, input, NUM_MASTERS: per-master lock, active-high; sampled only for the current owner, suppresses forced rotation.
- grnt, output, NUM_MASTERS: registered one-hot grant, active-high; all-zero when idle.
- owner, output, OWNER_W: index of the current or last owner; also the round-robin pointer.
- owner_valid, output, 1: high when any grnt bit is set.
- timeout, output, 1: one-cycle pulse on the cycle after a forced rotation edge.

Behaviour:
- Reset (async, immediate): grnt=0, owner=NUM_MASTERS-1, owner_valid=0, timeout=0, hold counter=0, state IDLE. Master 0 therefore wins first after reset.
- States:
  - IDLE: no grant.
  - GRANTED: exactly one grnt bit set, equal to bit [owner].
- Search order: always owner+1, owner+2, … wrapping modulo NUM_MASTERS, ending with owner itself. The first set req bit in that order wins.
- IDLE:
  - At each edge, if any req bit is set, grant the search winner. Then grnt[winner]=1, owner=winner, owner_valid=1, hold=0, go to GRANTED.
  - Grant latency is one cycle: req high before edge t gives grnt high after edge t.
- GRANTED, owner deasserts req:
  - If other requests exist, at the next edge grant moves directly to the search winner, excluding the owner. No idle cycle between grants; hold=0.
  - If no other requests exist: grnt=0, owner_valid=0, owner unchanged, go to IDLE.
- GRANTED, owner keeps req: grant is kept and hold increments, saturating at MAX_HOLD-1.
- Forced rotation: occurs at the edge where all of the following hold:
  - MAX_HOLD≠0,
  - hold==MAX_HOLD-1,
  - req[owner]=1,
  - lock[owner]=0,
  - another req bit is set.
  - Effect: grant moves to the search winner (excluding the owner), hold=0, and timeout=1 for the following cycle.
  - The owner therefore keeps the bus for exactly MAX_HOLD cycles under contention.
- Lock:
  - While lock[owner]=1, no forced rotation; hold stays saturated.
  - Deasserting lock at saturation allows rotation at the next edge if contention exists.
- Without contention there is no rotation, regardless of hold count.
- Requests appearing and disappearing in the same cycle: only values sampled at the edge matter. Glitches between edges are ignored.
- A req bit dropping for a non-owner has no effect. Masters must hold req until granted; no queuing is performed.
- Invariants:
  - grnt is never multi-hot.
  - grnt ≠ 0 if and only if owner_valid=1.
  - owner is always < NUM_MASTERS.
- Reset asserted mid-grant: grant drops asynchronously the same instant. After release, arbitration restarts from the master-0 priority.

Test Plan:
- Reset then req=4'b0110 → after 1st edge grnt=4'b0010, owner=1, owner_valid=1; req=0 → next edge grnt=0, owner stays 1.
- Round robin: grant to M0, then req=4'b1111 held with M0 dropping req after 2 cycles → grants M1, then M2, M3, M0 in order as each owner drops req, with no zero-grant cycle between.
- Timeout, MAX_HOLD=4: M2 holds req, M3 requests with lock=0 → M2 granted exactly 4 cycles, then grnt=4'b1000 and timeout pulses 1 cycle.
- Lock: same as the timeout case with lock[2]=1 for 10 cycles → M2 granted for all 10 cycles; lock[2]→0 → M3 granted next edge, timeout=1.
- MAX_HOLD=0, NUM_MASTERS=8: M5 holds req for 50 cycles while M1 and M7 request → no rotation; M5 drops req → M7 granted (search from 6).
- Async reset mid-grant with grnt=4'b0100 → grnt=0 before the next edge; after release with req=4'b1111 → M0 granted.
